// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the decoder, the ID/EX register and the EX stage.
package cpu_pkg;

    localparam int ALU_OP_W = 4;
    localparam int REG_W    = 5;

    localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'h0;
    localparam logic [REG_W-1:0]    NOP_RW  = '0;

    // Control bits that travel with an instruction from ID into EX.
    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_op:    ALU_NOP
    };

    // An invalid slot must never write the register file or touch memory,
    // whatever the decoder left on those lines.
    function automatic ctrl_t gate_ctrl(input ctrl_t c);
        ctrl_t g;
        g = c;
        if (!c.valid) begin
            g.reg_write = 1'b0;
            g.mem_read  = 1'b0;
            g.mem_write = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Bundle of pipeline-control, ID-stage and EX-stage signals around the ID/EX register.
interface id_ex_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    import cpu_pkg::*;

    logic                hold;
    logic                flush;
    logic                conflict_stall;

    logic                valid_id;
    logic                reg_write_id;
    logic                mem_read_id;
    logic                mem_write_id;
    logic [ALU_OP_W-1:0] alu_op_id;
    logic [DATA_W-1:0]   pc_id;
    logic [DATA_W-1:0]   r1_data_id;
    logic [DATA_W-1:0]   r2_data_id;
    logic [DATA_W-1:0]   imm_id;
    logic [REG_W-1:0]    rw_id;

    logic                valid_ex;
    logic                reg_write_ex;
    logic                mem_read_ex;
    logic                mem_write_ex;
    logic [ALU_OP_W-1:0] alu_op_ex;
    logic [DATA_W-1:0]   pc_ex;
    logic [DATA_W-1:0]   r1_data_ex;
    logic [DATA_W-1:0]   r2_data_ex;
    logic [DATA_W-1:0]   imm_ex;
    logic [REG_W-1:0]    rw_ex;
    logic                load_ex;

    logic [CNT_W-1:0]    bubble_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output hold, flush, conflict_stall,
        output valid_id, reg_write_id, mem_read_id, mem_write_id, alu_op_id,
        output pc_id, r1_data_id, r2_data_id, imm_id, rw_id,
        input  valid_ex, reg_write_ex, mem_read_ex, mem_write_ex, alu_op_ex,
        input  pc_ex, r1_data_ex, r2_data_ex, imm_ex, rw_ex, load_ex,
        input  bubble_cnt, flush_cnt
    );

    modport slave (
        input  hold, flush, conflict_stall,
        input  valid_id, reg_write_id, mem_read_id, mem_write_id, alu_op_id,
        input  pc_id, r1_data_id, r2_data_id, imm_id, rw_id,
        output valid_ex, reg_write_ex, mem_read_ex, mem_write_ex, alu_op_ex,
        output pc_ex, r1_data_ex, r2_data_ex, imm_ex, rw_ex, load_ex,
        output bubble_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled events until every bit is set, then hold there.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and load-use bubble insertion.
module id_ex_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input logic        clk,
    input logic        rst,
    id_ex_reg_if.slave bus
);

    ctrl_t             ctrl_q;
    logic [REG_W-1:0]  rw_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] r1_q;
    logic [DATA_W-1:0] r2_q;
    logic [DATA_W-1:0] imm_q;

    logic              do_flush;
    logic              do_bubble;
    logic              do_kill;
    logic              do_load;
    ctrl_t             ctrl_in;

    logic [CNT_W-1:0]  bubble_count;
    logic [CNT_W-1:0]  flush_count;

    // Hold wins over everything but reset; flush wins over a load-use bubble.
    assign do_flush  = !bus.hold && bus.flush;
    assign do_bubble = !bus.hold && !bus.flush && bus.conflict_stall;
    assign do_kill   = do_flush || do_bubble;
    assign do_load   = !bus.hold && !bus.flush && !bus.conflict_stall;

    assign ctrl_in = gate_ctrl('{
        valid:     bus.valid_id,
        reg_write: bus.reg_write_id,
        mem_read:  bus.mem_read_id,
        mem_write: bus.mem_write_id,
        alu_op:    bus.alu_op_id
    });

    // Control group: reset or kill to NOP, load from ID, otherwise keep.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= NOP_CTRL;
            rw_q   <= NOP_RW;
        end else if (do_kill) begin
            ctrl_q <= NOP_CTRL;
            rw_q   <= NOP_RW;
        end else if (do_load) begin
            ctrl_q <= ctrl_in;
            rw_q   <= bus.rw_id;
        end
    end

    // Datapath group: zeroed alongside the control bits so a NOP carries no stale operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            imm_q <= '0;
        end else if (do_kill) begin
            pc_q  <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            imm_q <= '0;
        end else if (do_load) begin
            pc_q  <= bus.pc_id;
            r1_q  <= bus.r1_data_id;
            r2_q  <= bus.r2_data_id;
            imm_q <= bus.imm_id;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (do_bubble),
        .count (bubble_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (do_flush),
        .count (flush_count)
    );

    assign bus.valid_ex     = ctrl_q.valid;
    assign bus.reg_write_ex = ctrl_q.reg_write;
    assign bus.mem_read_ex  = ctrl_q.mem_read;
    assign bus.mem_write_ex = ctrl_q.mem_write;
    assign bus.alu_op_ex    = ctrl_q.alu_op;
    assign bus.pc_ex        = pc_q;
    assign bus.r1_data_ex   = r1_q;
    assign bus.r2_data_ex   = r2_q;
    assign bus.imm_ex       = imm_q;

    // Hazard-facing outputs depend only on registered state, so a non-writing
    // or empty slot (and register zero) can never raise a false dependency.
    assign bus.rw_ex   = (ctrl_q.valid && ctrl_q.reg_write) ? rw_q : NOP_RW;
    assign bus.load_ex = ctrl_q.valid && ctrl_q.mem_read;

    assign bus.bubble_cnt = bubble_count;
    assign bus.flush_cnt  = flush_count;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed, table-driven bench for the ID/EX pipeline register.
module tb_id_ex_reg;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int NUM_VEC = 15;

    typedef struct packed {
        logic              rst;
        logic              hold;
        logic              flush;
        logic              stall;
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [3:0]        alu;
        logic [4:0]        rw;
        logic [31:0]       pc;
        logic [31:0]       r1;
        logic [31:0]       r2;
        logic [31:0]       imm;
    } in_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [3:0]        alu;
        logic [4:0]        rw;
        logic              load;
        logic [31:0]       pc;
        logic [31:0]       r1;
        logic [31:0]       r2;
        logic [31:0]       imm;
        logic [CNT_W-1:0]  bub;
        logic [CNT_W-1:0]  flu;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   num_checks = 0;
    int   num_errors = 0;

    vec_t vecs [NUM_VEC];
    in_t  id_a, id_b, id_c, id_d, id_e, id_f, id_g;
    out_t ex_a, ex_b, ex_d, ex_e, ex_f, ex_g;

    id_ex_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic in_t ctl(input in_t id, input logic r, input logic h,
                                input logic f, input logic s);
        in_t t;
        t       = id;
        t.rst   = r;
        t.hold  = h;
        t.flush = f;
        t.stall = s;
        return t;
    endfunction

    function automatic out_t cnt(input out_t o, input logic [CNT_W-1:0] b,
                                 input logic [CNT_W-1:0] f);
        out_t t;
        t     = o;
        t.bub = b;
        t.flu = f;
        return t;
    endfunction

    function automatic out_t nop(input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] f);
        out_t t;
        t     = '0;
        t.bub = b;
        t.flu = f;
        return t;
    endfunction

    task automatic checkField(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input out_t e);
        checkField({tag, ".valid_ex"},     32'(bus.valid_ex),     32'(e.valid));
        checkField({tag, ".reg_write_ex"}, 32'(bus.reg_write_ex), 32'(e.reg_write));
        checkField({tag, ".mem_read_ex"},  32'(bus.mem_read_ex),  32'(e.mem_read));
        checkField({tag, ".mem_write_ex"}, 32'(bus.mem_write_ex), 32'(e.mem_write));
        checkField({tag, ".alu_op_ex"},    32'(bus.alu_op_ex),    32'(e.alu));
        checkField({tag, ".rw_ex"},        32'(bus.rw_ex),        32'(e.rw));
        checkField({tag, ".load_ex"},      32'(bus.load_ex),      32'(e.load));
        checkField({tag, ".pc_ex"},        bus.pc_ex,             e.pc);
        checkField({tag, ".r1_data_ex"},   bus.r1_data_ex,        e.r1);
        checkField({tag, ".r2_data_ex"},   bus.r2_data_ex,        e.r2);
        checkField({tag, ".imm_ex"},       bus.imm_ex,            e.imm);
        checkField({tag, ".bubble_cnt"},   32'(bus.bubble_cnt),   32'(e.bub));
        checkField({tag, ".flush_cnt"},    32'(bus.flush_cnt),    32'(e.flu));
    endtask

    task automatic driveInputs(input in_t s);
        rst                = s.rst;
        bus.hold           = s.hold;
        bus.flush          = s.flush;
        bus.conflict_stall = s.stall;
        bus.valid_id       = s.valid;
        bus.reg_write_id   = s.reg_write;
        bus.mem_read_id    = s.mem_read;
        bus.mem_write_id   = s.mem_write;
        bus.alu_op_id      = s.alu;
        bus.rw_id          = s.rw;
        bus.pc_id          = s.pc;
        bus.r1_data_id     = s.r1;
        bus.r2_data_id     = s.r2;
        bus.imm_id         = s.imm;
    endtask

    // Drive on the falling edge, let one rising edge pass, sample just after it.
    task automatic applyStimulus(input in_t s);
        @(negedge clk);
        driveInputs(s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ID-stage instructions (pipeline-control bits filled in per vector).
        id_a = '{rst:0, hold:0, flush:0, stall:0, valid:1, reg_write:1, mem_read:1, mem_write:0,
                 alu:4'h2, rw:5'd8, pc:32'h0040_0010, r1:32'h0000_0011, r2:32'h0000_0022, imm:32'h0000_0004};
        id_b = '{rst:0, hold:0, flush:0, stall:0, valid:1, reg_write:1, mem_read:0, mem_write:1,
                 alu:4'h3, rw:5'd5, pc:32'h0040_0020, r1:32'hAAAA_0000, r2:32'h0000_5555, imm:32'hFFFF_FFFC};
        id_c = '{rst:0, hold:0, flush:0, stall:0, valid:1, reg_write:1, mem_read:1, mem_write:1,
                 alu:4'h7, rw:5'd9, pc:32'hDEAD_0000, r1:32'h0000_0001, r2:32'h0000_0002, imm:32'h0000_0003};
        id_d = '{rst:0, hold:0, flush:0, stall:0, valid:1, reg_write:1, mem_read:1, mem_write:0,
                 alu:4'h1, rw:5'd0, pc:32'h0000_0030, r1:32'h0000_0005, r2:32'h0000_0006, imm:32'h0000_0007};
        id_e = '{rst:0, hold:0, flush:0, stall:0, valid:0, reg_write:1, mem_read:1, mem_write:1,
                 alu:4'h5, rw:5'd7, pc:32'h0000_0044, r1:32'h0000_0008, r2:32'h0000_0009, imm:32'h0000_000A};
        id_f = '{rst:0, hold:0, flush:0, stall:0, valid:1, reg_write:1, mem_read:0, mem_write:0,
                 alu:4'hF, rw:5'd31, pc:32'hFFFF_FFFC, r1:32'hFFFF_FFFF, r2:32'h0000_0000, imm:32'h8000_0000};
        id_g = '{rst:0, hold:0, flush:0, stall:0, valid:1, reg_write:0, mem_read:1, mem_write:0,
                 alu:4'h6, rw:5'd12, pc:32'h0000_0050, r1:32'h0000_0000, r2:32'h0000_0000, imm:32'h0000_0000};

        // Hand-computed EX-stage images of the above after a plain load.
        ex_a = '{valid:1, reg_write:1, mem_read:1, mem_write:0, alu:4'h2, rw:5'd8, load:1,
                 pc:32'h0040_0010, r1:32'h0000_0011, r2:32'h0000_0022, imm:32'h0000_0004, bub:0, flu:0};
        ex_b = '{valid:1, reg_write:1, mem_read:0, mem_write:1, alu:4'h3, rw:5'd5, load:0,
                 pc:32'h0040_0020, r1:32'hAAAA_0000, r2:32'h0000_5555, imm:32'hFFFF_FFFC, bub:0, flu:0};
        ex_d = '{valid:1, reg_write:1, mem_read:1, mem_write:0, alu:4'h1, rw:5'd0, load:1,
                 pc:32'h0000_0030, r1:32'h0000_0005, r2:32'h0000_0006, imm:32'h0000_0007, bub:0, flu:0};
        ex_e = '{valid:0, reg_write:0, mem_read:0, mem_write:0, alu:4'h5, rw:5'd0, load:0,
                 pc:32'h0000_0044, r1:32'h0000_0008, r2:32'h0000_0009, imm:32'h0000_000A, bub:0, flu:0};
        ex_f = '{valid:1, reg_write:1, mem_read:0, mem_write:0, alu:4'hF, rw:5'd31, load:0,
                 pc:32'hFFFF_FFFC, r1:32'hFFFF_FFFF, r2:32'h0000_0000, imm:32'h8000_0000, bub:0, flu:0};
        ex_g = '{valid:1, reg_write:0, mem_read:1, mem_write:0, alu:4'h6, rw:5'd0, load:1,
                 pc:32'h0000_0050, r1:32'h0000_0000, r2:32'h0000_0000, imm:32'h0000_0000, bub:0, flu:0};

        vecs[0]  = '{ctl(id_a, 0, 0, 0, 0), cnt(ex_a, 0, 0)};
        vecs[1]  = '{ctl(id_a, 0, 0, 0, 1), nop(1, 0)};
        vecs[2]  = '{ctl(id_a, 0, 0, 0, 0), cnt(ex_a, 1, 0)};
        vecs[3]  = '{ctl(id_a, 1, 1, 0, 0), nop(0, 0)};
        vecs[4]  = '{ctl(id_b, 0, 0, 0, 0), cnt(ex_b, 0, 0)};
        vecs[5]  = '{ctl(id_c, 0, 1, 1, 1), cnt(ex_b, 0, 0)};
        vecs[6]  = '{ctl(id_c, 0, 1, 1, 1), cnt(ex_b, 0, 0)};
        vecs[7]  = '{ctl(id_c, 0, 1, 1, 1), cnt(ex_b, 0, 0)};
        vecs[8]  = '{ctl(id_c, 0, 0, 1, 1), nop(0, 1)};
        vecs[9]  = '{ctl(id_d, 0, 0, 0, 0), cnt(ex_d, 0, 1)};
        vecs[10] = '{ctl(id_e, 0, 0, 0, 0), cnt(ex_e, 0, 1)};
        vecs[11] = '{ctl(id_e, 0, 0, 1, 0), nop(0, 2)};
        vecs[12] = '{ctl(id_f, 0, 0, 0, 0), cnt(ex_f, 0, 2)};
        vecs[13] = '{ctl(id_g, 0, 0, 0, 0), cnt(ex_g, 0, 2)};
        vecs[14] = '{ctl(id_g, 0, 0, 1, 1), nop(0, 3)};

        // Reset state.
        driveInputs(ctl(id_a, 1, 0, 0, 0));
        @(posedge clk);
        #1;
        checkOutput("reset", nop(0, 0));

        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vecs[i].stim);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // EX outputs must not follow ID inputs between edges.
        applyStimulus(ctl(id_a, 0, 0, 0, 0));
        checkOutput("comb_pre", cnt(ex_a, 0, 3));
        #2;
        driveInputs(ctl(id_c, 0, 0, 1, 1));
        #1;
        checkOutput("comb_post", cnt(ex_a, 0, 3));

        // Reset mid-stream discards EX, the next edge loads normally.
        applyStimulus(ctl(id_a, 1, 0, 0, 0));
        checkOutput("rst_mid", nop(0, 0));
        applyStimulus(ctl(id_b, 0, 0, 0, 0));
        checkOutput("rst_after", cnt(ex_b, 0, 0));

        // Bubble counter climbs to all-ones and stays there.
        applyStimulus(ctl(id_a, 1, 0, 0, 0));
        checkOutput("sat_rst", nop(0, 0));
        for (int i = 0; i < 17; i++) begin
            logic [CNT_W-1:0] eb;
            eb = (i >= 14) ? 4'hF : CNT_W'(i + 1);
            applyStimulus(ctl(id_a, 0, 0, 0, 1));
            checkOutput($sformatf("sat%0d", i + 1), nop(eb, 0));
        end
        applyStimulus(ctl(id_a, 0, 0, 1, 0));
        checkOutput("sat_flush", nop(4'hF, 1));

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
